// File: rtl/mac_loader_if.sv
// Port bundle for mac_loader: upstream word stream, packed mac operand buses,
// mac result return path and downstream result handshake.
interface mac_loader_if #(
  parameter int N_WORDS = 64,
  parameter int DATA_W  = 16
);
  logic                        in_valid;
  logic                        in_ready;
  logic signed [DATA_W-1:0]    in_data;
  logic [DATA_W*N_WORDS-1:0]   data_bus;
  logic [DATA_W*N_WORDS-1:0]   weight_bus;
  logic                        mac_start;
  logic signed [DATA_W-1:0]    mac_result;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [DATA_W-1:0]    out_data;
  logic                        busy;

  // Environment side: feeds words and the mac result, consumes the output.
  modport master (
    output in_valid, in_data, mac_result, out_ready,
    input  in_ready, data_bus, weight_bus, mac_start, out_valid, out_data, busy
  );

  // Loader side.
  modport slave (
    input  in_valid, in_data, mac_result, out_ready,
    output in_ready, data_bus, weight_bus, mac_start, out_valid, out_data, busy
  );
endinterface

// File: rtl/mac_loader.sv
// mac_loader: gathers an N_WORDS data vector then a weight vector, fires the mac,
// and holds its result for a downstream handshake. Option macro: MAC_LOADER_CLEAR_EN.
module mac_loader #(
  parameter int N_WORDS = 64,
  parameter int MAC_LAT = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  mac_loader_if.slave lb
);
  localparam int DATA_W = 16;
  localparam int CNT_W  = $clog2(N_WORDS) + 1;
  localparam int LAT_W  = 4;

  typedef enum logic [1:0] {LOAD_D, LOAD_W, WAIT, OUT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] word_cnt;
  logic [LAT_W-1:0] wait_cnt;
  logic             rdy_en;
  logic             loading;
  logic             accept;
  logic             last_word;
  logic             wait_last;
  logic             out_hs;

  // rdy_en keeps in_ready low while reset is held and for the release cycle.
  assign loading   = rdy_en && ((state == LOAD_D) || (state == LOAD_W));
  assign accept    = lb.in_valid && loading;
  assign last_word = (word_cnt == CNT_W'(N_WORDS - 1));
  assign wait_last = (wait_cnt == LAT_W'(MAC_LAT));
  assign out_hs    = (state == OUT) && lb.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= LOAD_D;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    lb.in_ready  = 1'b0;
    lb.mac_start = 1'b0;
    lb.out_valid = 1'b0;
    lb.busy      = 1'b0;
    case (state)
      LOAD_D: begin
        lb.in_ready = loading;
        if (accept && last_word) state_nxt = LOAD_W;
      end
      LOAD_W: begin
        lb.in_ready = loading;
        if (accept && last_word) state_nxt = WAIT;
      end
      WAIT: begin
        lb.busy      = 1'b1;
        lb.mac_start = (wait_cnt == '0);
        if (wait_last) state_nxt = OUT;
      end
      OUT: begin
        lb.busy      = 1'b1;
        lb.out_valid = 1'b1;
        if (lb.out_ready) state_nxt = LOAD_D;
      end
      default: state_nxt = LOAD_D;
    endcase
  end

  // Counters: word index within the current vector, cycles spent in WAIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_en   <= 1'b0;
      word_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        word_cnt <= last_word ? '0 : word_cnt + 1'b1;
      end else if (out_hs) begin
        word_cnt <= '0;
      end
      if (state == WAIT) begin
        wait_cnt <= wait_last ? '0 : wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Operand buses and result capture; buses are frozen outside the load states.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lb.data_bus   <= '0;
      lb.weight_bus <= '0;
      lb.out_data   <= '0;
    end else begin
      for (int k = 0; k < N_WORDS; k++) begin
        if (accept && (word_cnt == CNT_W'(k))) begin
          if (state == LOAD_D) begin
            lb.data_bus[DATA_W*k +: DATA_W] <= lb.in_data;
          end else begin
            lb.weight_bus[DATA_W*k +: DATA_W] <= lb.in_data;
          end
        end
      end
      if ((state == WAIT) && wait_last) begin
        lb.out_data <= lb.mac_result;
      end
`ifdef MAC_LOADER_CLEAR_EN
      if (out_hs) begin
        lb.data_bus   <= '0;
        lb.weight_bus <= '0;
      end
`else
      // Buses keep the last vector until new words overwrite them.
`endif
    end
  end

endmodule

// File: tb/tb_mac_loader.sv
// Randomized self-checking bench for mac_loader against a vector-level reference model.
module tb_mac_loader;
  localparam int N   = 64;
  localparam int LAT = 3;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  // Reference model: expected operand words and position in the 2*N word stream.
  logic [15:0] exp_d [N];
  logic [15:0] exp_w [N];
  int          model_cnt;

  mac_loader_if #(.N_WORDS(N)) lb ();

  mac_loader #(.N_WORDS(N), .MAC_LAT(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .lb      (lb)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      exp_d[k] = 16'h0000;
      exp_w[k] = 16'h0000;
    end
    model_cnt = 0;
  endtask

  task automatic model_accept(input logic [15:0] v);
    if (model_cnt < N) exp_d[model_cnt] = v;
    else               exp_w[model_cnt - N] = v;
    model_cnt = (model_cnt + 1) % (2 * N);
  endtask

  function automatic int first_diff(input logic [16*N-1:0] bus, input bit wsel);
    for (int k = 0; k < N; k++) begin
      if (bus[16*k +: 16] !== (wsel ? exp_w[k] : exp_d[k])) return k;
    end
    return -1;
  endfunction

  function automatic logic [15:0] noise(input logic [15:0] avoid);
    logic [15:0] n;
    n = 16'($urandom);
    if (n == avoid) n = ~n;
    return n;
  endfunction

  // mode 0: constant cval, 1: (index within vector)+1, 2: random values.
  task automatic stream(input int n, input int mode, input logic [15:0] cval,
                        input bit rnd_valid, input string tag);
    int          done;
    int          cycles;
    bit          go;
    logic [15:0] v;
    done   = 0;
    cycles = 0;
    while (done < n && cycles < 5000) begin
      @(negedge clk);
      cycles++;
      go = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      case (mode)
        0:       v = cval;
        1:       v = 16'((model_cnt % N) + 1);
        default: v = 16'($urandom);
      endcase
      lb.in_valid  = go;
      lb.in_data   = v;
      lb.out_ready = 1'($urandom_range(0, 1));
      if (go && lb.in_ready) begin
        model_accept(v);
        done++;
      end
    end
    checks++;
    if (done < n) begin
      errors++;
      $display("FAIL %s stream_timeout: accepted %0d, required %0d", tag, done, n);
    end
  endtask

  // Called right after the final weight accept; walks WAIT into OUT.
  task automatic run_wait(input string tag, input logic [15:0] res);
    for (int c = 0; c <= LAT + 1; c++) begin
      @(negedge clk);
      checks++;
      if (lb.mac_start !== 1'(c == 0)) begin
        errors++;
        $display("FAIL %s mac_start cycle %0d: got %b, required %b", tag, c, lb.mac_start, c == 0);
      end
      checks++;
      if (lb.out_valid !== 1'(c == LAT + 1)) begin
        errors++;
        $display("FAIL %s out_valid cycle %0d: got %b, required %b", tag, c, lb.out_valid, c == LAT + 1);
      end
      checks++;
      if (lb.busy !== 1'b1 || lb.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s busy/in_ready cycle %0d: got %b/%b, required 1/0", tag, c, lb.busy, lb.in_ready);
      end
      lb.in_valid   = 1'($urandom_range(0, 1));
      lb.in_data    = 16'($urandom);
      lb.mac_result = (c == LAT) ? res : noise(res);
      lb.out_ready  = (c < LAT) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    checks++;
    if (lb.out_data !== res) begin
      errors++;
      $display("FAIL %s out_data: got %h, required %h", tag, lb.out_data, res);
    end
  endtask

  task automatic do_handshake(input string tag);
    int idx;
    lb.out_ready = 1'b1;
    @(negedge clk);
    lb.out_ready = 1'b0;
    lb.in_valid  = 1'b0;
`ifdef MAC_LOADER_CLEAR_EN
    for (int k = 0; k < N; k++) begin
      exp_d[k] = 16'h0000;
      exp_w[k] = 16'h0000;
    end
`endif
    checks++;
    if (lb.out_valid !== 1'b0 || lb.busy !== 1'b0 || lb.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s post_handshake out_valid/busy/in_ready: got %b/%b/%b, required 0/0/1",
               tag, lb.out_valid, lb.busy, lb.in_ready);
    end
    checks++;
    idx = first_diff(lb.data_bus, 1'b0);
    if (idx >= 0) begin
      errors++;
      $display("FAIL %s post_handshake data_bus word %0d: got %h, required %h",
               tag, idx, lb.data_bus[16*idx +: 16], exp_d[idx]);
    end
    checks++;
    idx = first_diff(lb.weight_bus, 1'b1);
    if (idx >= 0) begin
      errors++;
      $display("FAIL %s post_handshake weight_bus word %0d: got %h, required %h",
               tag, idx, lb.weight_bus[16*idx +: 16], exp_w[idx]);
    end
  endtask

  task automatic test_reset();
    lb.in_valid   = 1'b0;
    lb.in_data    = 16'h0000;
    lb.mac_result = 16'h0000;
    lb.out_ready  = 1'b0;
    reset_n       = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    checks++;
    if (lb.in_ready !== 1'b0 || lb.out_valid !== 1'b0 || lb.mac_start !== 1'b0 || lb.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset ctrl in_ready/out_valid/mac_start/busy: got %b/%b/%b/%b, required 0/0/0/0",
               lb.in_ready, lb.out_valid, lb.mac_start, lb.busy);
    end
    checks++;
    if (lb.data_bus !== '0 || lb.weight_bus !== '0 || lb.out_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset data buses/out_data nonzero: out_data got %h, required 0000", lb.out_data);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (lb.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset in_ready_after_release: got %b, required 1", lb.in_ready);
    end
  endtask

  task automatic test_basic_stream();
    int idx;
    stream(N, 0, 16'h0100, 1'b0, "basic_data");
    stream(N, 0, 16'h0200, 1'b0, "basic_weight");
    run_wait("basic", 16'hABCD);
    checks++;
    idx = first_diff(lb.data_bus, 1'b0);
    if (idx >= 0 || lb.data_bus[15:0] !== 16'h0100) begin
      errors++;
      $display("FAIL basic data_bus: word0 got %h, required 0100 (first diff %0d)", lb.data_bus[15:0], idx);
    end
    checks++;
    idx = first_diff(lb.weight_bus, 1'b1);
    if (idx >= 0 || lb.weight_bus[16*N-1 -: 16] !== 16'h0200) begin
      errors++;
      $display("FAIL basic weight_bus: top word got %h, required 0200 (first diff %0d)",
               lb.weight_bus[16*N-1 -: 16], idx);
    end
  endtask

  task automatic test_out_hold();
    int idx;
    for (int c = 0; c < 10; c++) begin
      lb.in_valid  = 1'b1;
      lb.in_data   = 16'($urandom);
      lb.out_ready = 1'b0;
      lb.mac_result = 16'($urandom);
      @(negedge clk);
      checks++;
      if (lb.out_valid !== 1'b1 || lb.out_data !== 16'hABCD || lb.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold cycle %0d out_valid/out_data/in_ready: got %b/%h/%b, required 1/abcd/0",
                 c, lb.out_valid, lb.out_data, lb.in_ready);
      end
      checks++;
      idx = first_diff(lb.data_bus, 1'b0);
      if (idx < 0) idx = first_diff(lb.weight_bus, 1'b1);
      if (idx >= 0) begin
        errors++;
        $display("FAIL hold cycle %0d bus word %0d changed: data %h weight %h, required %h %h",
                 c, idx, lb.data_bus[16*idx +: 16], lb.weight_bus[16*idx +: 16], exp_d[idx], exp_w[idx]);
      end
    end
    do_handshake("hold");
  endtask

  task automatic test_random_valid();
    logic [15:0] res;
    logic [15:0] want;
    int          bad;
    stream(N, 1, 16'h0000, 1'b1, "kplus1_data");
    stream(N, 2, 16'h0000, 1'b1, "rand_weight");
    res = 16'($urandom);
    run_wait("random", res);
    bad = -1;
    for (int k = 0; k < N; k++) begin
      want = 16'(k + 1);
      if (bad < 0 && lb.data_bus[16*k +: 16] !== want) bad = k;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL random data_bus word %0d: got %h, required %h", bad, lb.data_bus[16*bad +: 16], 16'(bad + 1));
    end
    checks++;
    bad = first_diff(lb.weight_bus, 1'b1);
    if (bad >= 0) begin
      errors++;
      $display("FAIL random weight_bus word %0d: got %h, required %h", bad, lb.weight_bus[16*bad +: 16], exp_w[bad]);
    end
    do_handshake("random");
  endtask

  task automatic test_reset_mid();
    int idx;
    stream(37, 2, 16'h0000, 1'b0, "pre_reset");
    @(negedge clk);
    lb.in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (lb.in_ready !== 1'b0 || lb.out_valid !== 1'b0 || lb.mac_start !== 1'b0 || lb.busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset ctrl in_ready/out_valid/mac_start/busy: got %b/%b/%b/%b, required 0/0/0/0",
               lb.in_ready, lb.out_valid, lb.mac_start, lb.busy);
    end
    checks++;
    if (lb.data_bus !== '0 || lb.weight_bus !== '0 || lb.out_data !== 16'h0000) begin
      errors++;
      $display("FAIL midreset buses not cleared: data word0 %h, out_data %h, required 0000",
               lb.data_bus[15:0], lb.out_data);
    end
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    stream(N, 2, 16'h0000, 1'b1, "post_reset");
    @(negedge clk);
    lb.in_valid = 1'b0;
    checks++;
    idx = first_diff(lb.data_bus, 1'b0);
    if (idx >= 0) begin
      errors++;
      $display("FAIL midreset refill data_bus word %0d: got %h, required %h", idx, lb.data_bus[16*idx +: 16], exp_d[idx]);
    end
    checks++;
    if (lb.weight_bus !== '0 || lb.in_ready !== 1'b1 || lb.busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset weight_bus/in_ready/busy: word0 %h in_ready %b busy %b, required 0000/1/0",
               lb.weight_bus[15:0], lb.in_ready, lb.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] res;
    // Finish the vector left in LOAD_W, then run a second one with no idle gap.
    stream(N, 2, 16'h0000, 1'b0, "b2b_weight0");
    res = 16'($urandom);
    run_wait("b2b0", res);
    do_handshake("b2b0");
    stream(2 * N, 2, 16'h0000, 1'b0, "b2b_vec1");
    res = 16'($urandom);
    run_wait("b2b1", res);
    do_handshake("b2b1");
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_out_hold();
    test_random_valid();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_loader.md
MAC_LOADER -- requirements
Module: mac_loader

Interface
REQ-001 Parameter N_WORDS, default 64: operand words per vector, matching the mac operand count.
REQ-002 Parameter MAC_LAT, default 3: clock edges from operand-bus stable to mac result valid; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  upstream word valid.
REQ-006 in_ready  output  1  loader can accept a word.
REQ-007 in_data  input  16  Q8.8 operand word.
REQ-008 data_bus  output  16*N_WORDS  packed data operands; word k at bits [16k+15:16k].
REQ-009 weight_bus  output  16*N_WORDS  packed weight operands; same packing.
REQ-010 mac_start  output  1  one-cycle pulse marking operands stable for the mac.
REQ-011 mac_result  input  16  Q8.8 dot-product result from the mac.
REQ-012 out_valid  output  1  captured result available.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_data  output  16  captured result.
REQ-015 busy  output  1  high in WAIT or OUT.

Function
REQ-016 The FSM SHALL have states LOAD_D, LOAD_W, WAIT, OUT; reset state LOAD_D.
REQ-017 A word SHALL be accepted only on a rising edge with in_valid=1 and in_ready=1.
REQ-018 in_ready SHALL be 1 exactly in LOAD_D and LOAD_W, decoded from state only, with no dependence on in_valid.
REQ-019 In LOAD_D, accepted word number i (0-based, i = 0..N_WORDS-1) SHALL be written to data_bus word i; the N_WORDS-th accept SHALL move the FSM to LOAD_W and clear the word counter.
REQ-020 In LOAD_W, accepted word i SHALL be written to weight_bus word i; the N_WORDS-th accept SHALL move the FSM to WAIT.
REQ-021 mac_start SHALL be 1 in the first WAIT cycle only.
REQ-022 WAIT SHALL last exactly MAC_LAT+1 cycles; mac_result SHALL be registered into out_data on the rising edge that ends the last WAIT cycle, and the FSM SHALL then enter OUT.
REQ-023 data_bus and weight_bus SHALL hold their values throughout WAIT and OUT.
REQ-024 In OUT, out_valid SHALL be 1 and out_data SHALL be stable until an edge with out_ready=1; that edge SHALL return the FSM to LOAD_D with the word counter at 0.
REQ-025 out_ready asserted outside OUT SHALL have no effect; in_valid asserted outside LOAD_D/LOAD_W SHALL be ignored and no word SHALL be lost or written.
REQ-026 The word counter SHALL be ceil(log2(N_WORDS))+1 bits wide and SHALL never exceed N_WORDS-1 when written.
REQ-027 Back-to-back operation: in_ready SHALL rise in the cycle after the out handshake edge.

Reset
REQ-028 Assertion of reset_n=0 SHALL, asynchronously and at any point including mid-load or in OUT, force the state to LOAD_D, the counters to 0, data_bus=0, weight_bus=0, out_data=0, out_valid=0, mac_start=0, busy=0, in_ready=0.
REQ-029 in_ready SHALL first be 1 in the first cycle after reset_n deasserts.

Configuration
REQ-030 With macro MAC_LOADER_CLEAR_EN defined, the out handshake edge SHALL also clear data_bus and weight_bus to 0.
REQ-031 Without MAC_LOADER_CLEAR_EN, the buses SHALL retain the last vector until overwritten word by word.

Verification
REQ-032 Stream 64 words 0x0100, then 64 words 0x0200, with in_valid held at 1 -> every data_bus word = 0x0100, every weight_bus word = 0x0200, mac_start pulses 1 cycle after the 128th accept.
REQ-033 Bench drives mac_result=0xABCD only in the final WAIT cycle (default MAC_LAT=3) -> out_data=0xABCD, out_valid rises 4 cycles after mac_start.
REQ-034 Hold out_ready=0 for 10 cycles in OUT while in_valid=1 -> out_valid and out_data stay stable, in_ready stays 0, no bus change.
REQ-035 Pull reset_n low after 37 data accepts -> all outputs 0 immediately; the next 64 accepts fill data_bus from word 0.
REQ-036 Toggle in_valid pseudo-randomly (50%) with values k+1 -> data_bus word k = k+1 for k=0..63, with no gaps or duplicates.
REQ-037 With MAC_LOADER_CLEAR_EN defined, complete the out handshake -> both buses read all-zero in the next cycle; without the macro -> both buses are unchanged.
